// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with byte/half/word access, one request in flight.
// Optional access counters are enabled by defining DATA_MEM_STATS_EN.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_ctrl_if.slave  mem_if
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [15:0]     rd_count_o,
  output logic [15:0]     wr_count_o,
  output logic [15:0]     err_count_o
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       ld_idx_q, ld_idx_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [IdxW-1:0]       acc_idx;
  logic [1:0]            acc_off;
  logic                  acc_err;
  logic                  accept;
  logic                  mem_we;
  logic [3:0]            wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  // Shift the addressed lane(s) down to bit 0, then extend.
  function automatic logic [31:0] extract(logic [31:0] word, logic [1:0] off,
                                          logic [1:0] size, logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    unique case (size)
      2'b00:   extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  assign acc_idx = mem_if.req_addr[IdxW+1:2];
  assign acc_off = mem_if.req_addr[1:0];
  assign accept  = mem_if.req_valid && (state_q == StIdle);

  always_comb begin
    acc_err = 1'b0;
    if (mem_if.req_size == 2'b11)                             acc_err = 1'b1;
    if (mem_if.req_size == 2'b01 && acc_off[0])               acc_err = 1'b1;
    if (mem_if.req_size == 2'b10 && acc_off != 2'b00)         acc_err = 1'b1;
    if ((mem_if.req_addr >> (IdxW + 2)) != '0)                acc_err = 1'b1;
  end

  // Replicate the store data across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = mem_if.req_wdata;
    unique case (mem_if.req_size)
      2'b00: begin
        wr_be   = 4'b0001 << acc_off;
        wr_data = {4{mem_if.req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = 4'b0011 << acc_off;
        wr_data = {2{mem_if.req_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_idx_d  = ld_idx_q;
    ld_off_d  = ld_off_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (acc_err) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (mem_if.req_write) begin
            mem_we  = 1'b1;
            state_d = StResp;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            ld_idx_d  = acc_idx;
            ld_off_d  = acc_off;
            ld_size_d = mem_if.req_size;
            ld_uns_d  = mem_if.req_unsigned;
            cnt_d     = 2'(READ_LATENCY - 1);
            err_d     = 1'b0;
            if (READ_LATENCY <= 1) begin
              state_d = StResp;
              rdata_d = extract(mem_q[acc_idx], acc_off, mem_if.req_size, mem_if.req_unsigned);
            end else begin
              state_d = StAccess;
            end
          end
        end
      end
      StAccess: begin
        // Leaving when the count reaches 0 gives exactly READ_LATENCY cycles from accept.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = StResp;
          rdata_d = extract(mem_q[ld_idx_q], ld_off_q, ld_size_q, ld_uns_q);
        end
      end
      StResp: begin
        if (mem_if.rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      ld_idx_q  <= '0;
      ld_off_q  <= 2'd0;
      ld_size_q <= 2'd0;
      ld_uns_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_idx_q  <= ld_idx_d;
      ld_off_q  <= ld_off_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem_q[acc_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  assign mem_if.req_ready = (state_q == StIdle);
  assign mem_if.rsp_valid = (state_q == StResp);
  assign mem_if.rsp_rdata = rdata_q;
  assign mem_if.rsp_err   = err_q;

`ifdef DATA_MEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else if (accept) begin
      if (acc_err) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (mem_if.req_write) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: byte-array reference model, queued expectations,
// independent response monitor with random back-pressure.
module tb_data_mem_ctrl;

  localparam int unsigned RL = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          first_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef DATA_MEM_STATS_EN
  logic [15:0] rd_count, wr_count, err_count;
`endif

  data_mem_ctrl #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (256),
    .READ_LATENCY(RL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (bus)
`ifdef DATA_MEM_STATS_EN
    ,
    .rd_count_o (rd_count),
    .wr_count_o (wr_count),
    .err_count_o(err_count)
`endif
  );

  int   n_tests = 0;
  int   n_fail = 0;
  int   ncyc = 0;
  int   hold_cycles = 0;
  exp_t q[$];
  logic [7:0] mm [1024];
  int   m_rd = 0, m_wr = 0, m_err = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the access rules.
  task automatic model(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
    int a;
    logic [31:0] v;
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 10) != 0);
    rdata = 32'h0;
    a = int'(addr[9:0]);
    if (err) begin
      m_err++;
    end else if (wr) begin
      m_wr++;
      for (int i = 0; i < (1 << size); i++) mm[a + i] = wdata[8*i +: 8];
    end else begin
      m_rd++;
      v = 32'h0;
      for (int i = 0; i < (1 << size); i++) v[8*i +: 8] = mm[a + i];
      if (size == 2'b00)      rdata = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (size == 2'b01) rdata = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                    rdata = v;
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within 200 cycles");
      return;
    end
    model(wr, size, uns, addr, wdata, e.rdata, e.err);
    e.first_cyc = ncyc + ((!e.err && !wr) ? RL : 1);
    q.push_back(e);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_write    = $urandom_range(0, 1);
    bus.req_size     = 2'($urandom_range(0, 3));
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  // Response monitor: compares every presented response cycle against the queue head.
  initial begin : monitor
    logic prev_valid;
    logic chk_idle;
    logic rdy;
    exp_t e;
    prev_valid = 1'b0;
    chk_idle   = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        chk_idle   = 1'b0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (chk_idle) begin
        check("idle_after_handshake", {30'h0, bus.req_ready, bus.rsp_valid}, 32'h2);
        chk_idle = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
          bus.rsp_ready = 1'b1;
        end else begin
          e = q[0];
          if (!prev_valid) check("rsp_latency", 32'(ncyc), 32'(e.first_cyc));
          check("req_ready_busy", {31'h0, bus.req_ready}, 32'h0);
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
          if (hold_cycles > 0) begin
            rdy = 1'b0;
            hold_cycles--;
          end else begin
            rdy = 1'($urandom_range(0, 1));
          end
          bus.rsp_ready = rdy;
          if (rdy) begin
            void'(q.pop_front());
            chk_idle   = 1'b1;
            prev_valid = 1'b0;
          end else begin
            prev_valid = 1'b1;
          end
        end
      end else begin
        prev_valid = 1'b0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : driver
    logic [31:0] addr;
    logic [1:0]  size;
    int          n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) mm[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    rst_n = 1'b1;

    // Known contents for the first 16 words.
    for (int w = 0; w < 16; w++) issue(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA8001);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);

    // Back-pressure: response must hold for 5 stalled cycles.
    hold_cycles = 5;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    for (int t = 0; t < 300; t++) begin
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
      size = 2'($urandom_range(0, 3));
      if (size == 2'b11 && $urandom_range(0, 3) != 0) size = 2'b10;
      issue(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
    end

    // Reset while a load is in its access phase.
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
    q.delete();
    m_rd = 0;
    m_wr = 0;
    m_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h2, 32'h7F);
    issue(1'b0, 2'b00, 1'b0, 32'h2, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h3, 32'h0);

    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
    repeat (2) @(negedge clk);

`ifdef DATA_MEM_STATS_EN
    check("rd_count", {16'h0, rd_count}, 32'(m_rd));
    check("wr_count", {16'h0, wr_count}, 32'(m_wr));
    check("err_count", {16'h0, err_count}, 32'(m_err));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
